// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: program memory read port plus the processor DIN/Run/Done handshake.
// The fetch unit is the master. Memory and processor sit on the slave side.
interface instr_fetch_if #(
  parameter int AW = 8
);
  logic [AW-1:0] MemAddr;
  logic          MemRd;
  logic [15:0]   MemData;
  logic [15:0]   DIN;
  logic          Run;
  logic          Done;

  modport master (
    output MemAddr, MemRd, DIN, Run,
    input  MemData, Done
  );

  modport slave (
    input  MemAddr, MemRd, DIN, Run,
    output MemData, Done
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer for the 16-bit bus processor: fetches words from a synchronous
// program memory, strobes Run, waits for Done, and tracks PC, halt and a stuck-instruction watchdog.
module instr_fetch #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [AW-1:0]      StartAddr,
  instr_fetch_if.master      bus,
  output logic [AW-1:0]      PC,
  output logic [15:0]        InstrCount,
  output logic               Halted,
  output logic               Error
);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int         WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_FETCH_IMM,
    S_LATCH_IMM,
    S_ISSUE,
    S_IMMED,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t         state;
  logic [15:0]    ibuf;
  logic [15:0]    imm;
  logic [WDW-1:0] wd_cnt;

  // All outputs are registered and loaded on the transition into the state that presents them,
  // so each output is valid for the whole cycle spent in that state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: the instruction/immediate buffers are ordinary flops, not a RAM, so they are reset
      // along with everything else and DIN can never show stale data after a reset.
      state       <= S_IDLE;
      PC          <= '0;
      InstrCount  <= '0;
      ibuf        <= '0;
      imm         <= '0;
      wd_cnt      <= '0;
      Halted      <= 1'b0;
      Error       <= 1'b0;
      bus.MemAddr <= '0;
      bus.MemRd   <= 1'b0;
      bus.DIN     <= '0;
      bus.Run     <= 1'b0;
    end else begin
      // NOTE: these defaults are non-blocking like every other assignment here; a later
      // assignment in the case below overrides them, which turns MemRd/Run into one-cycle pulses.
      bus.MemRd <= 1'b0;
      bus.Run   <= 1'b0;
      bus.DIN   <= '0;

      case (state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (Start) begin
            PC          <= StartAddr;
            bus.MemAddr <= StartAddr;
            bus.MemRd   <= 1'b1;
            Halted      <= 1'b0;
            Error       <= 1'b0;
            state       <= S_FETCH;
          end
        end

        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          ibuf <= bus.MemData;
          if (bus.MemData[8:6] == OP_HALT) begin
            // PC stays on the halt word so software can see where the program stopped.
            Halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            PC <= PC + AW'(1);
            if (bus.MemData[8:6] == OP_MVI) begin
              bus.MemAddr <= PC + AW'(1);
              bus.MemRd   <= 1'b1;
              state       <= S_FETCH_IMM;
            end else begin
              bus.DIN <= bus.MemData;
              bus.Run <= 1'b1;
              state   <= S_ISSUE;
            end
          end
        end

        S_FETCH_IMM: state <= S_LATCH_IMM;

        S_LATCH_IMM: begin
          imm     <= bus.MemData;
          PC      <= PC + AW'(1);
          bus.DIN <= ibuf;
          bus.Run <= 1'b1;
          state   <= S_ISSUE;
        end

        S_ISSUE: begin
          wd_cnt <= '0;
          if (ibuf[8:6] == OP_MVI) begin
            bus.DIN <= imm;
            state   <= S_IMMED;
          end else begin
            state <= S_WAIT;
          end
        end

        // mvi must complete in the cycle its immediate is on DIN; anything else gets TIMEOUT cycles.
        S_IMMED, S_WAIT: begin
          if (bus.Done) begin
            if (InstrCount != 16'hFFFF) InstrCount <= InstrCount + 16'd1;
            bus.MemAddr <= PC;
            bus.MemRd   <= 1'b1;
            state       <= S_FETCH;
          end else if (state == S_IMMED || wd_cnt == WDW'(TIMEOUT - 1)) begin
            Error <= 1'b1;
            state <= S_ERROR;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: program memory and a behavioural bus processor around the DUT, with a
// program-walking reference model predicting fetch addresses, issued words, timing and final state.
module tb_instr_fetch;
  localparam int AW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [AW-1:0] StartAddr = '0;
  logic [AW-1:0] PC;
  logic [15:0]   InstrCount;
  logic          Halted;
  logic          Error;

  instr_fetch_if #(.AW(AW)) bus ();

  instr_fetch #(.AW(AW), .TIMEOUT(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .bus        (bus.master),
    .PC         (PC),
    .InstrCount (InstrCount),
    .Halted     (Halted),
    .Error      (Error)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Synchronous program memory.
  logic [15:0] mem [256];
  always @(posedge Clock) if (bus.MemRd) bus.MemData <= mem[bus.MemAddr];

  // Behavioural processor: Done high when idle; mv/mvi finish 1 cycle after Run, add/sub after 3,
  // opcodes 100-110 never finish. A new Run always replaces whatever it was doing.
  logic [15:0] p_reg [8];
  logic        p_busy;
  logic [15:0] p_ir;
  int          p_step;

  function automatic int p_need(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: return 1;
      3'b010, 3'b011: return 3;
      default:        return 0;
    endcase
  endfunction

  assign bus.Done = !p_busy || (p_need(p_ir[8:6]) != 0 && p_step == p_need(p_ir[8:6]));

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      p_busy <= 1'b0;
      p_ir   <= '0;
      p_step <= 0;
      for (int r = 0; r < 8; r++) p_reg[r] <= '0;
    end else if (bus.Run) begin
      p_busy <= 1'b1;
      p_ir   <= bus.DIN;
      p_step <= 1;
    end else if (p_busy) begin
      if (bus.Done) begin
        p_busy <= 1'b0;
        case (p_ir[8:6])
          3'b000: p_reg[p_ir[5:3]] <= p_reg[p_ir[2:0]];
          3'b001: p_reg[p_ir[5:3]] <= bus.DIN;
          3'b010: p_reg[p_ir[5:3]] <= p_reg[p_ir[5:3]] + p_reg[p_ir[2:0]];
          3'b011: p_reg[p_ir[5:3]] <= p_reg[p_ir[5:3]] - p_reg[p_ir[2:0]];
          default: ;
        endcase
      end else begin
        p_step <= p_step + 1;
      end
    end
  end

  // Bus monitor: fetch addresses and every word the processor sees as an instruction or immediate.
  logic [7:0]  obs_fetch [$];
  logic [15:0] obs_issue [$];
  bit          mon_en   = 1'b0;
  bit          imm_next = 1'b0;
  int          first_run = -1;
  int          t0 = 0;

  always @(negedge Clock) begin
    if (mon_en) begin
      if (bus.MemRd) obs_fetch.push_back(bus.MemAddr);
      if (bus.Run || imm_next) obs_issue.push_back(bus.DIN);
      if (bus.Run && first_run < 0) first_run = cyc - t0;
      imm_next = bus.Run && (bus.DIN[8:6] == 3'b001);
    end
  end

  // Reference model state.
  logic [7:0]  exp_fetch [$];
  logic [15:0] exp_issue [$];
  logic [15:0] m_reg [8];
  logic [15:0] exp_count;
  logic [7:0]  exp_pc;
  logic        exp_halt;
  logic        exp_err;
  int          exp_edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Walks the program from sa and predicts everything the run should show. Cycle cost per
  // instruction: mv 4, mvi 6, add/sub 6, plus one cycle to leave the start state and two for halt.
  task automatic ref_run(input logic [7:0] sa);
    logic [7:0]  pc;
    logic [15:0] w;
    logic [2:0]  rx, ry;
    bit          stop;
    pc = sa;
    stop = 1'b0;
    exp_fetch.delete();
    exp_issue.delete();
    exp_edges = 1;
    exp_halt  = 1'b0;
    exp_err   = 1'b0;
    for (int n = 0; n < 256 && !stop; n++) begin
      w  = mem[pc];
      rx = w[5:3];
      ry = w[2:0];
      exp_fetch.push_back(pc);
      case (w[8:6])
        3'b111: begin
          exp_halt = 1'b1; exp_edges += 2; stop = 1'b1;
        end
        3'b001: begin
          exp_fetch.push_back(pc + 8'd1);
          exp_issue.push_back(w);
          exp_issue.push_back(mem[pc + 8'd1]);
          m_reg[rx] = mem[pc + 8'd1];
          pc += 8'd2; exp_edges += 6; exp_count = sat_inc(exp_count);
        end
        3'b000: begin
          exp_issue.push_back(w);
          m_reg[rx] = m_reg[ry];
          pc += 8'd1; exp_edges += 4; exp_count = sat_inc(exp_count);
        end
        3'b010, 3'b011: begin
          exp_issue.push_back(w);
          m_reg[rx] = (w[8:6] == 3'b010) ? m_reg[rx] + m_reg[ry] : m_reg[rx] - m_reg[ry];
          pc += 8'd1; exp_edges += 6; exp_count = sat_inc(exp_count);
        end
        default: begin
          exp_issue.push_back(w);
          exp_err = 1'b1; pc += 8'd1; exp_edges += 7; stop = 1'b1;
        end
      endcase
    end
    exp_pc = pc;
  endtask

  // Starts a program at sa and checks it against the model. With noisy set, Start is also
  // raised at random while a program is executing, which must have no effect.
  task automatic run_prog(input logic [7:0] sa, input bit noisy, input string tag);
    int edges;
    int n_issue;
    ref_run(sa);
    obs_fetch.delete();
    obs_issue.delete();
    imm_next  = 1'b0;
    first_run = -1;
    @(negedge Clock);
    StartAddr = sa;
    Start     = 1'b1;
    t0        = cyc;
    for (int i = 0; i < exp_edges + 40; i++) begin
      @(negedge Clock);
      if (Halted || Error) break;
      Start = noisy && ($urandom_range(0, 4) == 0);
      if (Start) StartAddr = 8'($urandom);
    end
    Start = 1'b0;
    edges = cyc - t0;
    check({tag, " cycles"}, 32'(edges), 32'(exp_edges));
    check({tag, " Halted"}, 32'(Halted), 32'(exp_halt));
    check({tag, " Error"}, 32'(Error), 32'(exp_err));
    check({tag, " PC"}, 32'(PC), 32'(exp_pc));
    check({tag, " InstrCount"}, 32'(InstrCount), 32'(exp_count));
    check({tag, " fetch count"}, 32'(obs_fetch.size()), 32'(exp_fetch.size()));
    for (int i = 0; i < obs_fetch.size() && i < exp_fetch.size(); i++)
      check($sformatf("%s fetch[%0d]", tag, i), 32'(obs_fetch[i]), 32'(exp_fetch[i]));
    check({tag, " issue count"}, 32'(obs_issue.size()), 32'(exp_issue.size()));
    for (int i = 0; i < obs_issue.size() && i < exp_issue.size(); i++)
      check($sformatf("%s issue[%0d]", tag, i), 32'(obs_issue[i]), 32'(exp_issue[i]));
    for (int r = 0; r < 8; r++)
      check($sformatf("%s R%0d", tag, r), 32'(p_reg[r]), 32'(m_reg[r]));
    n_issue = obs_issue.size();
    repeat (6) @(negedge Clock);
    check({tag, " no Run after stop"}, 32'(obs_issue.size()), 32'(n_issue));
    check({tag, " flags hold"}, {30'd0, Halted, Error}, {30'd0, exp_halt, exp_err});
  endtask

  task automatic do_reset();
    Start = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    for (int r = 0; r < 8; r++) m_reg[r] = '0;
    exp_count = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sa, a;
    logic [2:0] op;
    int         n;
    bit         found;

    for (int i = 0; i < 256; i++) mem[i] = 16'h01C0;
    for (int r = 0; r < 8; r++) m_reg[r] = '0;
    exp_count = '0;
    mon_en = 1'b1;

    // Reset state, then idle with the processor holding Done high.
    repeat (2) @(negedge Clock);
    check("reset PC", 32'(PC), 32'd0);
    check("reset InstrCount", 32'(InstrCount), 32'd0);
    check("reset Halted/Error", {30'd0, Halted, Error}, 32'd0);
    check("reset Run/MemRd", {30'd0, bus.Run, bus.MemRd}, 32'd0);
    check("reset DIN", 32'(bus.DIN), 32'd0);
    check("reset MemAddr", 32'(bus.MemAddr), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("idle Run/MemRd", {30'd0, bus.Run, bus.MemRd}, 32'd0);
    check("idle PC", 32'(PC), 32'd0);
    check("idle flags", {30'd0, Halted, Error}, 32'd0);

    // mv R0,R1 then halt.
    mem[0] = 16'h0001;
    mem[1] = 16'h01C0;
    run_prog(8'h00, 1'b0, "mv");
    check("mv Run cycle", 32'(first_run), 32'd3);
    check("mv PC at halt", 32'(PC), 32'd1);

    // mvi R0,#BEEF at address 4.
    do_reset();
    mem[4] = 16'h0040;
    mem[5] = 16'hBEEF;
    mem[6] = 16'h01C0;
    run_prog(8'h04, 1'b0, "mvi");
    check("mvi R0 value", 32'(p_reg[0]), 32'h0000BEEF);
    check("mvi PC at halt", 32'(PC), 32'd6);
    check("mvi count", 32'(InstrCount), 32'd1);

    // mvi R0,5; mvi R1,3; sub R0,R1; halt.
    do_reset();
    mem[0] = 16'h0040; mem[1] = 16'h0005;
    mem[2] = 16'h0048; mem[3] = 16'h0003;
    mem[4] = 16'h00C1; mem[5] = 16'h01C0;
    run_prog(8'h00, 1'b1, "sub");
    check("sub R0 value", 32'(p_reg[0]), 32'd2);
    check("sub count", 32'(InstrCount), 32'd3);

    // Unimplemented opcode trips the watchdog; Start recovers from StartAddr.
    do_reset();
    mem[0] = 16'h0100;
    run_prog(8'h00, 1'b0, "watchdog");
    mem[0] = 16'h0001;
    mem[1] = 16'h01C0;
    run_prog(8'h00, 1'b0, "recover");

    // PC wraps from FF to 00.
    do_reset();
    mem[8'hFF] = 16'h0001;
    mem[8'h00] = 16'h01C0;
    run_prog(8'hFF, 1'b0, "wrap");
    check("wrap PC", 32'(PC), 32'd0);

    // Reset while an add is on DIN with Run high; outputs must drop before the next edge.
    do_reset();
    mem[0] = 16'h0040; mem[1] = 16'h0005;
    mem[2] = 16'h0048; mem[3] = 16'h0003;
    mem[4] = 16'h0081; mem[5] = 16'h01C0;
    @(negedge Clock);
    StartAddr = 8'h00;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.Run && bus.DIN == 16'h0081) found = 1'b1;
      else @(negedge Clock);
    end
    check("add reached issue", 32'(found), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async reset Run", 32'(bus.Run), 32'd0);
    check("async reset DIN", 32'(bus.DIN), 32'd0);
    check("async reset PC", 32'(PC), 32'd0);
    check("async reset MemRd", 32'(bus.MemRd), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int r = 0; r < 8; r++) m_reg[r] = '0;
    exp_count = '0;
    run_prog(8'h00, 1'b0, "after reset");
    check("after reset R0", 32'(p_reg[0]), 32'd8);

    // Random programs, some straddling the top of memory, some ending on a bad opcode.
    for (int p = 0; p < 12; p++) begin
      sa = ($urandom_range(0, 3) == 0) ? 8'(8'hF6 + $urandom_range(0, 9)) : 8'($urandom);
      a  = sa;
      n  = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        op = 3'($urandom_range(0, 3));
        mem[a] = {7'($urandom), op, 6'($urandom)};
        a += 8'd1;
        if (op == 3'b001) begin
          mem[a] = 16'($urandom);
          a += 8'd1;
        end
      end
      if ($urandom_range(0, 3) == 0) mem[a] = {7'd0, 3'(3'd4 + 3'($urandom_range(0, 2))), 6'($urandom)};
      else                           mem[a] = {7'($urandom), 3'b111, 6'($urandom)};
      run_prog(sa, 1'b1, $sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch/issue sequencer directly upstream of the 16-bit bus processor.
- Reads instruction words (and mvi immediates) from a synchronous program memory, presents them on the processor's DIN, and pulses Run.
- Waits for the processor's Done before fetching the next word.
- Owns the program counter, halt detection and a stuck-instruction watchdog.

Parameters:
- AW, 8, program memory address width; PC wraps modulo 2^AW.
- TIMEOUT, 4, maximum WAIT cycles without Done before flagging Error.

Ports:
- Clock  in  1  system clock, all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; sampled in IDLE/HALTED/ERROR; loads PC from StartAddr and begins fetching.
- StartAddr  in  AW  initial program counter.
- MemAddr  out  AW  program memory read address.
- MemRd  out  1  memory read strobe; data valid on MemData the following cycle.
- MemData  in  16  program memory read data.
- DIN  out  16  word presented to processor DIN.
- Run  out  1  processor run strobe; high for exactly one cycle per instruction.
- Done  in  1  processor end-of-instruction, combinational from processor.
- PC  out  AW  current program counter.
- InstrCount  out  16  instructions completed, saturating at 16'hFFFF.
- Halted  out  1  halt opcode reached.
- Error  out  1  watchdog expired.

Behaviour:
- Reset (asynchronous): state=IDLE; PC=0; InstrCount=0; instruction and immediate buffers=0.
- All outputs are 0 while Reset is asserted and in IDLE.
- Opcode field is word[8:6]:
  - 000 mv
  - 001 mvi
  - 010 add
  - 011 sub
  - 111 halt
  - 100–110 are issued unchanged; the watchdog catches them.
- States and transitions:
  - IDLE: Start=1 -> PC<=StartAddr, go to FETCH.
  - FETCH: MemAddr=PC, MemRd=1; go to LATCH.
  - LATCH: IBUF<=MemData, PC<=PC+1.
    - opcode 111 -> HALTED; PC not advanced past halt, so PC holds the halt address.
    - opcode 001 -> FETCH_IMM.
    - otherwise -> ISSUE.
  - FETCH_IMM: MemAddr=PC, MemRd=1; go to LATCH_IMM.
  - LATCH_IMM: IMM<=MemData, PC<=PC+1; go to ISSUE.
  - ISSUE: DIN=IBUF, Run=1, watchdog cleared.
    - mvi -> IMMED; others -> WAIT.
  - IMMED: DIN=IMM, Run=0.
    - Done=1 -> count, go to FETCH.
    - Done=0 -> ERROR.
  - WAIT: DIN=16'h0000, Run=0, watchdog counts cycles.
    - Done=1 -> count, go to FETCH.
    - TIMEOUT cycles elapsed without Done -> ERROR.
  - HALTED: Halted=1. Start=1 -> reload PC from StartAddr, go to FETCH.
  - ERROR: Error=1. Start=1 -> reload PC from StartAddr, go to FETCH.
- Done is ignored in every state except IMMED and WAIT. The processor asserts Done when idle, so it is not a completion indication there.
- Latency per instruction, in cycles from FETCH entry to the next FETCH:
  - mv: 4
  - add/sub: 6
  - mvi: 6
- MemRd is high only in FETCH and FETCH_IMM; MemAddr holds its last value otherwise.
- PC wraps from 2^AW-1 to 0 without any flag. An mvi at the top address takes its immediate from address 0.
- Start while in FETCH through WAIT is ignored.
- Reset asserted mid-instruction drops Run and DIN to 0 immediately, asynchronously.
- The processor's own Resetn is driven separately by the system. Both resets are tied by the system so the processor returns to T0 together with this block.

Test Plan:
- mv sequence: mem[0]=16'h0001 (mv R0,R1), mem[1]=16'h01C0 (halt); Start with StartAddr=0.
  - Run high exactly 1 cycle, at cycle 3, with DIN=16'h0001.
  - Done accepted at cycle 4.
  - Halted=1; PC=1; InstrCount=1.
- mvi: mem[4]=16'h0040, mem[5]=16'hBEEF, mem[6]=halt; StartAddr=4.
  - DIN=16'h0040 with Run=1, then DIN=16'hBEEF with Run=0 in the next cycle.
  - Processor R0=16'hBEEF; PC=6; InstrCount=1.
- add/sub: mvi R0,5; mvi R1,3; sub R0,R1 (16'h00C1); halt.
  - Each sub instruction spends 3 WAIT cycles.
  - Processor R0=2; InstrCount=3.
- Watchdog: mem[0]=16'h0100 (opcode 100).
  - Error=1 after Run plus 4 WAIT cycles; Run never reasserts.
  - Start recovers and refetches from StartAddr.
- Wrap (AW=8): StartAddr=8'hFF; mem[FF]=mv, mem[00]=halt.
  - Fetch addresses FF then 00; Halted with PC=0.
- Reset in WAIT of an add:
  - Run/DIN/PC go to 0 without waiting for Clock.
  - After release, a new Start executes the program from the beginning correctly.
